// File: rtl/tick_pulse_stretcher_pkg.sv
// tick_pulse_stretcher_pkg: shared state type and effective-length helper
package tick_pulse_stretcher_pkg;
    localparam int EFF_W = 32;
    typedef enum logic [1:0] {IDLE, HIGH, GAP} stretch_state_t;
    function automatic logic [EFF_W-1:0] eff_len(input logic [EFF_W-1:0] value);
        return (value == '0) ? EFF_W'(1) : value;
    endfunction
endpackage

// File: rtl/tick_pulse_stretcher_load_down_counter.sv
// load_down_counter: loadable down-counter that saturates at zero
module load_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);
    assign zero = (count == '0);
    // load wins over decrement; decrement stops at zero so it never wraps
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else if (load) count <= load_val;
        else if (dec && !zero) count <= count - CNT_W'(1);
    end
endmodule

// File: rtl/tick_pulse_stretcher.sv
// tick_pulse_stretcher: stretches a one-cycle tick into a level pulse followed by a low gap
module tick_pulse_stretcher
    import tick_pulse_stretcher_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int RETRIGGER = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic [CNT_W-1:0] len,
    input  logic [CNT_W-1:0] gap,
    output logic             level,
    output logic             busy,
    output logic             drop
);
    stretch_state_t   state, next;
    logic [CNT_W-1:0] gap_q, gap_d, load_val, count, len_eff, gap_eff;
    logic             load, dec, zero, drop_d;
    assign len_eff = CNT_W'(eff_len(EFF_W'(len)));
    assign gap_eff = CNT_W'(eff_len(EFF_W'(gap)));
    assign busy    = (state != IDLE);
    load_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .dec      (dec),
        .load_val (load_val),
        .count    (count),
        .zero     (zero)
    );
    // next-state, counter control and drop decision
    always_comb begin
        next     = state;
        load     = 1'b0;
        dec      = 1'b0;
        load_val = len_eff - CNT_W'(1);
        gap_d    = gap_q;
        drop_d   = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    next  = HIGH;
                    load  = 1'b1;
                    gap_d = gap_eff;
                end
            end
            HIGH: begin
                if (tick && RETRIGGER != 0) begin
                    load  = 1'b1;
                    gap_d = gap_eff;
                end else begin
                    drop_d = tick;
                    if (zero) begin
                        next     = GAP;
                        load     = 1'b1;
                        load_val = gap_q - CNT_W'(1);
                    end else begin
                        dec = 1'b1;
                    end
                end
            end
            GAP: begin
                drop_d = tick;
                if (zero) next = IDLE;
                else dec = 1'b1;
            end
            default: next = IDLE;
        endcase
    end
    // state and registered outputs; level tracks the state we are entering
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            gap_q <= CNT_W'(1);
            level <= 1'b0;
            drop  <= 1'b0;
        end else begin
            state <= next;
            gap_q <= gap_d;
            level <= (next == HIGH);
            drop  <= drop_d;
        end
    end
endmodule

// File: tb/tb_tick_pulse_stretcher.sv
// tb_tick_pulse_stretcher: checks both RETRIGGER variants against a timeline model
module tb_tick_pulse_stretcher;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] len = '0;
    logic [7:0] gap = '0;
    logic       level0, busy0, drop0, level1, busy1, drop1;
    int         tests = 0;
    int         failed = 0;
    int         cyc = 0;
    int         hi_end [2] = '{-1, -1};
    int         busy_end [2] = '{-1, -1};
    int         drop_at [2] = '{-1, -1};

    tick_pulse_stretcher #(.CNT_W(8), .RETRIGGER(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .len(len), .gap(gap),
        .level(level0), .busy(busy0), .drop(drop0)
    );
    tick_pulse_stretcher #(.CNT_W(8), .RETRIGGER(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .len(len), .gap(gap),
        .level(level1), .busy(busy1), .drop(drop1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [2:0] got(input int k);
        return k ? {level1, busy1, drop1} : {level0, busy0, drop0};
    endfunction

    // Timeline model: an accepted tick at cycle t makes level high through t+len_eff
    // and busy through t+len_eff+gap_eff; any other tick flags drop on t+1.
    function automatic logic [2:0] expect_out(input int k);
        return {cyc <= hi_end[k], cyc <= busy_end[k], drop_at[k] == cyc};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            hi_end[k] = -1;
            busy_end[k] = -1;
            drop_at[k] = -1;
        end
    endtask

    task automatic drive(input logic t);
        int le, ge;
        le = (len == 0) ? 1 : int'(len);
        ge = (gap == 0) ? 1 : int'(gap);
        tick = t;
        if (t) begin
            for (int k = 0; k < 2; k++) begin
                if (cyc > busy_end[k] || (k == 1 && cyc <= hi_end[k])) begin
                    hi_end[k] = cyc + le;
                    busy_end[k] = hi_end[k] + ge;
                end else begin
                    drop_at[k] = cyc + 1;
                end
            end
        end
        @(posedge clk);
        #1 tick = 1'b0;
        cyc++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (got(k) !== 3'b000) begin
                    failed++;
                    $display("FAIL reset i=%0d dut%0d got %b required 000", i, k, got(k));
                end
            end
            tick = ~tick;
        end
        tick = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        len = 8'd3;
        gap = 8'd2;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (got(k) !== expect_out(k)) begin
                    failed++;
                    $display("FAIL basic cyc=%0d dut%0d got lvl/busy/drop=%b required %b", cyc, k, got(k), expect_out(k));
                end
            end
            drive(i == 1);
        end
    endtask

    task automatic test_zero_len();
        len = 8'd0;
        gap = 8'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (got(k) !== expect_out(k)) begin
                    failed++;
                    $display("FAIL zero_len cyc=%0d dut%0d got lvl/busy/drop=%b required %b", cyc, k, got(k), expect_out(k));
                end
            end
            drive(i == 1 || i == 4);
        end
    endtask

    task automatic test_drop();
        len = 8'd4;
        gap = 8'd1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (got(k) !== expect_out(k)) begin
                    failed++;
                    $display("FAIL drop cyc=%0d dut%0d got lvl/busy/drop=%b required %b", cyc, k, got(k), expect_out(k));
                end
            end
            drive(i == 1 || i == 3 || i == 6);
        end
    endtask

    task automatic test_retrigger();
        gap = 8'd2;
        for (int i = 0; i < 20; i++) begin
            len = (i >= 3) ? 8'd6 : 8'd4;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (got(k) !== expect_out(k)) begin
                    failed++;
                    $display("FAIL retrigger cyc=%0d dut%0d got lvl/busy/drop=%b required %b", cyc, k, got(k), expect_out(k));
                end
            end
            drive(i == 1 || i == 3);
        end
    endtask

    task automatic test_max();
        len = 8'hff;
        gap = 8'hff;
        for (int i = 0; i < 530; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (got(k) !== expect_out(k)) begin
                    failed++;
                    $display("FAIL max cyc=%0d dut%0d got lvl/busy/drop=%b required %b", cyc, k, got(k), expect_out(k));
                end
            end
            drive(i == 0 || i == 515);
        end
    endtask

    task automatic test_async_reset();
        len = 8'd8;
        gap = 8'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(i == 0);
        end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (got(k) !== 3'b000) begin
                failed++;
                $display("FAIL async_reset dut%0d got lvl/busy/drop=%b required 000 before any edge", k, got(k));
            end
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (got(k) !== expect_out(k)) begin
                    failed++;
                    $display("FAIL post_reset cyc=%0d dut%0d got lvl/busy/drop=%b required %b", cyc, k, got(k), expect_out(k));
                end
            end
            drive(i == 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            len = 8'($urandom_range(0, 7));
            gap = 8'($urandom_range(0, 5));
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (got(k) !== expect_out(k)) begin
                    failed++;
                    $display("FAIL random cyc=%0d dut%0d got lvl/busy/drop=%b required %b", cyc, k, got(k), expect_out(k));
                end
            end
            drive($urandom_range(0, 2) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_drop();
        test_retrigger();
        test_max();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/tick_pulse_stretcher.md
Name: tick_pulse_stretcher

Overview:
- Converts a one-cycle `tick` strobe into a level pulse of programmable high length, followed by a guaranteed low gap.
- This is the inverse of the team's rising-edge detectors: each accepted tick yields exactly one clean rising edge on `level`.
- Sits between control FSMs that emit ticks and slow consumers, such as LEDs, external enables, or edge-detecting blocks in other logic.

Parameters:
- CNT_W, 8, width of the `len`/`gap` inputs and the internal down-counter.
- RETRIGGER, 0, 1 = a tick during HIGH reloads the high length; 0 = that tick is dropped.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle request strobe, synchronous to clk.
- len  input  CNT_W  high length in cycles; 0 is treated as 1.
- gap  input  CNT_W  low guard length in cycles; 0 is treated as 1.
- level  output  1  stretched pulse, registered.
- busy  output  1  high while in HIGH or GAP.
- drop  output  1  one-cycle pulse: a tick was ignored.

Behaviour:
- Clocking and reset: single clock domain. Asserting reset_n=0 immediately forces state=IDLE, level=0, drop=0, counter=0, busy=0, and the latched gap register=1, even mid-pulse. After release, operation resumes from IDLE.
- Effective values: len_eff = (len==0) ? 1 : len; gap_eff = (gap==0) ? 1 : gap. Both are computed at CNT_W width with no overflow.
- States: IDLE, HIGH, GAP. level is 1 iff state==HIGH, registered, so no combinational path from tick.
- busy = (state != IDLE), decoded from the state register.
- IDLE:
  - tick=1 → next state HIGH, counter <= len_eff-1, gap_q <= gap_eff (gap sampled at acceptance).
  - tick=0 → stay in IDLE.
- HIGH (exactly len_eff cycles absent retrigger):
  - tick=1 and RETRIGGER=1 → stay in HIGH, counter <= len_eff-1 (len resampled), gap_q <= gap_eff. This takes priority over expiry.
  - tick=1 and RETRIGGER=0 → tick ignored; drop=1 next cycle. Counting continues normally.
  - Otherwise, counter!=0 → decrement. counter==0 → next state GAP, counter <= gap_q-1.
- GAP (exactly gap_q cycles, level=0):
  - Any tick → drop=1 next cycle, ignored; this includes the last GAP cycle.
  - counter!=0 → decrement. counter==0 → next state IDLE.
- Latency: tick accepted at cycle N → level=1 on cycles N+1 .. N+len_eff, level=0 on N+len_eff+1 .. N+len_eff+gap_eff, busy=0 from N+len_eff+gap_eff+1. Minimum accepted tick period = 1+len_eff+gap_eff cycles.
- drop is a registered pulse: high exactly one cycle per ignored tick, otherwise 0.
- len/gap changes take effect only at acceptance or at a retrigger.
- Maximum lengths (all ones) must work with no wrap; the counter never underflows.

Decomposition:
- Package tick_pulse_stretcher_pkg holds:
  - state enum typedef stretch_state_t {IDLE, HIGH, GAP};
  - a function eff_len(value) returning max(value,1).
- One sub-module, load_down_counter (CNT_W-bit down-counter with load, decrement, and zero flag), is natural and reusable. The FSM and output registers stay in the top module.

Test Plan:
- Reset: hold reset_n=0 with tick toggling → level=0, busy=0, drop=0 throughout. Release → IDLE, and the first tick is accepted.
- len=3, gap=2, tick at cycle 10 → level=1 on 11–13, busy=1 on 11–15, level=0 and busy=0 from 16, drop never asserted.
- len=0, gap=0, tick at cycle 5 → level=1 on cycle 6 only, GAP on cycle 7, IDLE at 8. A tick at cycle 8 is accepted, level=1 on cycle 9.
- RETRIGGER=0, len=4, gap=1, ticks at 10 and 12 → level=1 on 11–14 only, drop=1 on cycle 13. A tick at cycle 15 (GAP) → drop=1 on 16, no new pulse.
- RETRIGGER=1, len=4, ticks at 10 and 12 → level=1 continuously on 11–16, single rising edge, drop never asserted.
- Async reset: reset_n=0 asserted mid-HIGH (cycle 12 of a len=8 pulse) → level falls without waiting for a clock edge. After release, tick at cycle 20 → full len-cycle pulse from cycle 21.
